// File: rtl/demux12_stream.sv
// One-to-two stream demultiplexer with a one-entry output register per channel.
// Optional per-channel delivery counters are built when DEMUX12_STREAM_CNT_EN is defined.
module demux12_stream #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             s,
    input  logic             a_valid,
    output logic             a_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic             y0_valid,
    output logic             y1_valid,
    input  logic             y0_ready,
    input  logic             y1_ready,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t state0, state1;
    chan_state_t state0_nxt, state1_nxt;

    logic [WIDTH-1:0] data0, data1;
    logic             accept;
    logic             fill0, fill1;
    logic             drain0, drain1;

    assign y0_valid = (state0 == FULL);
    assign y1_valid = (state1 == FULL);
    assign y0       = data0;
    assign y1       = data1;

    // Only the selected channel gates acceptance, so a stalled channel never blocks the other.
    assign a_ready = s ? (!y1_valid || y1_ready) : (!y0_valid || y0_ready);
    assign accept  = a_valid && a_ready;
    assign fill0   = accept && !s;
    assign fill1   = accept && s;
    assign drain0  = y0_valid && y0_ready;
    assign drain1  = y1_valid && y1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state0 <= EMPTY;
            state1 <= EMPTY;
        end else begin
            state0 <= state0_nxt;
            state1 <= state1_nxt;
        end
    end

    always_comb begin
        state0_nxt = state0;
        state1_nxt = state1;
        case (state0)
            EMPTY:   if (fill0) state0_nxt = FULL;
            FULL:    if (drain0 && !fill0) state0_nxt = EMPTY;
            default: state0_nxt = EMPTY;
        endcase
        case (state1)
            EMPTY:   if (fill1) state1_nxt = FULL;
            FULL:    if (drain1 && !fill1) state1_nxt = EMPTY;
            default: state1_nxt = EMPTY;
        endcase
    end

    // Data is only written on refill, so a drained channel keeps showing its last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0 <= '0;
            data1 <= '0;
        end else begin
            if (fill0) data0 <= a;
            if (fill1) data1 <= a;
        end
    end

`ifdef DEMUX12_STREAM_CNT_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (drain0) cnt0_q <= cnt0_q + 16'd1;
            if (drain1) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux12_stream.sv
// Self-checking bench for demux12_stream: a directed vector table plus
// hand-written streaming, reset and (with DEMUX12_STREAM_CNT_EN) counter-wrap sequences.
module tb_demux12_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  a = '0;
    logic        s = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [7:0]  y0, y1;
    logic        y0_valid, y1_valid;
    logic        y0_ready = 1'b0;
    logic        y1_ready = 1'b0;
    logic [15:0] cnt0, cnt1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    demux12_stream #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .s        (s),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .y0       (y0),
        .y1       (y1),
        .y0_valid (y0_valid),
        .y1_valid (y1_valid),
        .y0_ready (y0_ready),
        .y1_ready (y1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic       s;
        logic       av;
        logic       r0;
        logic       r1;
        logic       rdy;
        logic       v0;
        logic [7:0] y0;
        logic       v1;
        logic [7:0] y1;
    } vec_t;

    vec_t vecs [0:12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outputs(input string tag, input logic v0e, input logic [7:0] y0e,
                               input logic v1e, input logic [7:0] y1e);
        chk({tag, "_y0_valid"}, {31'd0, y0_valid}, {31'd0, v0e});
        chk({tag, "_y0"},       {24'd0, y0},       {24'd0, y0e});
        chk({tag, "_y1_valid"}, {31'd0, y1_valid}, {31'd0, v1e});
        chk({tag, "_y1"},       {24'd0, y1},       {24'd0, y1e});
`ifndef DEMUX12_STREAM_CNT_EN
        chk({tag, "_cnt0"}, {16'd0, cnt0}, 32'd0);
        chk({tag, "_cnt1"}, {16'd0, cnt1}, 32'd0);
`endif
    endtask

    initial begin
        // a, s, av, r0, r1 | a_ready before edge | v0, y0, v1, y1 after edge
        vecs[0]  = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00};
        vecs[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00};
        vecs[2]  = '{8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h11};
        vecs[3]  = '{8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'h11};
        vecs[4]  = '{8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 8'h11};
        vecs[5]  = '{8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 8'h11};
        vecs[6]  = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 8'h11};
        vecs[7]  = '{8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 8'h11};
        vecs[8]  = '{8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h66, 1'b1, 8'h77};
        vecs[9]  = '{8'h88, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h66, 1'b0, 8'h77};
        vecs[10] = '{8'h99, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66, 1'b1, 8'h99};
        vecs[11] = '{8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 8'h99};
        vecs[12] = '{8'hBB, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 8'h99};

        // Reset held across clock edges
        repeat (2) step();
        chk_outputs("reset", 1'b0, 8'h00, 1'b0, 8'h00);
        chk("reset_cnt0", {16'd0, cnt0}, 32'd0);
        chk("reset_cnt1", {16'd0, cnt1}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_a_ready", {31'd0, a_ready}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            a        = vecs[i].a;
            s        = vecs[i].s;
            a_valid  = vecs[i].av;
            y0_ready = vecs[i].r0;
            y1_ready = vecs[i].r1;
            #1;
            chk($sformatf("v%0d_a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].rdy});
            step();
            chk_outputs($sformatf("v%0d", i), vecs[i].v0, vecs[i].y0, vecs[i].v1, vecs[i].y1);
        end

        // Back-to-back streaming on channel 0
        y0_ready = 1'b1;
        y1_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            logic [7:0] w;
            w = 8'(i);
            a       = w;
            s       = 1'b0;
            a_valid = 1'b1;
            #1;
            chk($sformatf("stream%0d_a_ready", i), {31'd0, a_ready}, 32'd1);
            step();
            chk($sformatf("stream%0d_y0", i), {24'd0, y0}, {24'd0, w});
            chk($sformatf("stream%0d_y0_valid", i), {31'd0, y0_valid}, 32'd1);
        end
        a_valid = 1'b0;
        step();
        chk("stream_end_y0_valid", {31'd0, y0_valid}, 32'd0);
        chk("stream_end_y0_hold", {24'd0, y0}, 32'h08);

        // Asynchronous reset while channel 0 holds a stalled word
        y0_ready = 1'b0;
        a        = 8'h5A;
        s        = 1'b0;
        a_valid  = 1'b1;
        step();
        a_valid = 1'b0;
        chk("midrst_loaded_y0", {24'd0, y0}, 32'h5A);
        chk("midrst_loaded_valid", {31'd0, y0_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs("midrst", 1'b0, 8'h00, 1'b0, 8'h00);
        chk("midrst_cnt0", {16'd0, cnt0}, 32'd0);
        chk("midrst_cnt1", {16'd0, cnt1}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_release_a_ready", {31'd0, a_ready}, 32'd1);
        y0_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("midrst_after%0d_y0_valid", i), {31'd0, y0_valid}, 32'd0);
            chk($sformatf("midrst_after%0d_y0", i), {24'd0, y0}, 32'd0);
        end

`ifdef DEMUX12_STREAM_CNT_EN
        // 65537 deliveries on channel 1 wrap its counter to 1
        y1_ready = 1'b1;
        s        = 1'b1;
        a_valid  = 1'b1;
        for (int unsigned i = 0; i < 65537; i++) begin
            a = i[7:0];
            step();
        end
        a_valid = 1'b0;
        step();
        chk("wrap_cnt1", {16'd0, cnt1}, 32'h0001);
        chk("wrap_cnt0", {16'd0, cnt0}, 32'h0000);
        chk("wrap_y1_valid", {31'd0, y1_valid}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
